// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and GF(2^8) helpers
package aes_pkg;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [3:0] NR = 4'd10;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/add_round_key_ks_if.sv
// add_round_key_ks_if: key load, state input and result output bundle
interface add_round_key_ks_if;
  logic key_load;
  logic [127:0] key_in;
  logic in_valid;
  logic in_ready;
  logic [127:0] din;
  logic out_valid;
  logic [127:0] dout;
  logic [3:0] out_round;
  modport master (
    output key_load, key_in, in_valid, din,
    input in_ready, out_valid, dout, out_round
  );
  modport slave (
    input key_load, key_in, in_valid, din,
    output in_ready, out_valid, dout, out_round
  );
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  output logic [BYTE_W-1:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[a];
endmodule

// File: rtl/add_round_key_ks.sv
// add_round_key_ks: AES-128 AddRoundKey with on-the-fly key schedule
module add_round_key_ks
  import aes_pkg::*;
(
  input logic clk,
  input logic rst_n,
  add_round_key_ks_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READY, EXPAND} state_t;
  state_t state_q, state_d;
  logic [127:0] ck_q, ck_d, rk_q, rk_d, dout_q, dout_d, next_rk;
  logic [3:0] rnd_q, rnd_d, out_round_q, out_round_d;
  logic [7:0] rcon_q, rcon_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, accept, expand, wrap;
  logic [WORD_W-1:0] rot_w, sub_w, temp, w0, w1, w2, w3;
  assign rot_w = {rk_q[23:0], rk_q[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_w[BYTE_W*i +: BYTE_W]), .y(sub_w[BYTE_W*i +: BYTE_W]));
  end
  always_comb begin
    temp = sub_w ^ {rcon_q, 24'h0};
    w0 = rk_q[127:96] ^ temp;
    w1 = rk_q[95:64] ^ w0;
    w2 = rk_q[63:32] ^ w1;
    w3 = rk_q[31:0] ^ w2;
    next_rk = {w0, w1, w2, w3};
    accept = state_q == READY && bus.in_valid && !bus.key_load;
    expand = state_q == EXPAND && !bus.key_load;
    wrap = rnd_q == NR;
    state_d = bus.key_load ? READY : accept ? EXPAND : state_q == EXPAND ? READY : state_q;
    ck_d = bus.key_load ? bus.key_in : ck_q;
    rk_d = bus.key_load ? bus.key_in : expand ? (wrap ? ck_q : next_rk) : rk_q;
    rnd_d = bus.key_load ? 4'd0 : expand ? (wrap ? 4'd0 : rnd_q + 4'd1) : rnd_q;
    rcon_d = bus.key_load ? RCON_INIT : expand ? (wrap ? RCON_INIT : xtime(rcon_q)) : rcon_q;
    in_ready_d = state_d == READY;
    out_valid_d = accept;
    dout_d = accept ? bus.din ^ rk_q : dout_q;
    out_round_d = accept ? rnd_q : out_round_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ck_q <= '0;
      rk_q <= '0;
      rnd_q <= '0;
      rcon_q <= RCON_INIT;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q <= '0;
      out_round_q <= '0;
    end else begin
      state_q <= state_d;
      ck_q <= ck_d;
      rk_q <= rk_d;
      rnd_q <= rnd_d;
      rcon_q <= rcon_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q <= dout_d;
      out_round_q <= out_round_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout = dout_q;
  assign bus.out_round = out_round_q;
endmodule

// File: tb/tb_add_round_key_ks.sv
// tb_add_round_key_ks: scoreboard bench against a field-arithmetic AES key schedule model
module tb_add_round_key_ks;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  add_round_key_ks_if bus();
  add_round_key_ks dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct { logic [127:0] d; logic [3:0] r; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0, failures = 0, n_out = 0;
  logic [127:0] last_dout = '0;
  logic [3:0] last_round = '0;
  logic [127:0] rk [0:10];
  int mrnd = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v = 8'h01;
    if (a == 8'h00) v = 8'h00;
    else for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      n_out++;
      last_dout = bus.dout;
      last_round = bus.out_round;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got out_valid round %0d want no output", bus.out_round);
      end else begin
        e = exp_q.pop_front();
        check("dout", bus.dout, e.d);
        check("out_round", 128'(bus.out_round), 128'(e.r));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [127:0] d);
    bus.in_valid = 1'b1;
    bus.din = d;
    for (int k = 0; k < 8; k++) begin
      if (bus.in_ready) begin
        exp_q.push_back('{d ^ rk[mrnd], 4'(mrnd)});
        mrnd = (mrnd == 10) ? 0 : mrnd + 1;
        tick();
        bus.in_valid = 1'b0;
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: in_ready got 0 want 1");
    bus.in_valid = 1'b0;
  endtask
  task automatic load(input logic [127:0] k, input logic v);
    bus.key_load = 1'b1;
    bus.key_in = k;
    bus.in_valid = v;
    bus.din = rnd128();
    tick();
    bus.key_load = 1'b0;
    bus.in_valid = 1'b0;
    expand(k);
    mrnd = 0;
  endtask
  task automatic wait_out(input int prev);
    for (int k = 0; k < 6; k++) begin
      if (n_out > prev) return;
      @(negedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL wait_out: got no out_valid want one");
  endtask
  task automatic check_reset_outputs();
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_dout", bus.dout, 128'(0));
    check("rst_out_round", 128'(bus.out_round), 128'(0));
  endtask
  task automatic idle_probe();
    int rdy = 0;
    int p = n_out;
    bus.in_valid = 1'b1;
    bus.din = rnd128();
    repeat (4) begin
      if (bus.in_ready) rdy++;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    check("idle_ready", 128'(rdy), 128'(0));
    check("idle_no_out", 128'(n_out - p), 128'(0));
  endtask
  initial begin
    int p, acc;
    bus.key_load = 1'b0;
    bus.key_in = '0;
    bus.in_valid = 1'b0;
    bus.din = '0;
    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    idle_probe();
    load(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    check("ready_after_load", 128'(bus.in_ready), 128'(1));
    p = n_out;
    send(128'h3243f6a8885a308d313198a2e0370734);
    wait_out(p);
    check("fips_r0_dout", last_dout, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("fips_r0_round", 128'(last_round), 128'(0));
    p = n_out;
    send(128'h046681e5e0cb199a48f8d37a2806264c);
    wait_out(p);
    check("fips_r1_dout", last_dout, 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("fips_r1_round", 128'(last_round), 128'(1));
    for (int r = 2; r <= 10; r++) begin
      p = n_out;
      send('0);
      wait_out(p);
    end
    check("fips_r10_key", last_dout, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_r10_round", 128'(last_round), 128'(10));
    p = n_out;
    send('0);
    wait_out(p);
    check("wrap_key", last_dout, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("wrap_round", 128'(last_round), 128'(0));
    acc = 0;
    bus.in_valid = 1'b1;
    bus.din = rnd128();
    for (int k = 0; k < 12; k++) begin
      if (bus.in_ready) begin
        exp_q.push_back('{bus.din ^ rk[mrnd], 4'(mrnd)});
        mrnd = (mrnd == 10) ? 0 : mrnd + 1;
        acc++;
        tick();
        bus.din = rnd128();
      end else tick();
    end
    bus.in_valid = 1'b0;
    check("held_valid_accepts", 128'(acc), 128'(6));
    repeat (2) tick();
    load(rnd128(), 1'b1);
    p = n_out;
    send(rnd128());
    wait_out(p);
    check("collision_round", 128'(last_round), 128'(0));
    repeat (5) send(rnd128());
    load(rnd128(), 1'b0);
    p = n_out;
    send(rnd128());
    wait_out(p);
    check("abort_round", 128'(last_round), 128'(0));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(9) == 0) load(rnd128(), 1'($urandom_range(1)));
      else send(rnd128());
      repeat ($urandom_range(2)) tick();
    end
    repeat (4) tick();
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    send(rnd128());
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    idle_probe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/add_round_key_ks.md
# add_round_key_ks

- AES-128 AddRoundKey stage with an integrated on-the-fly key schedule.
- Sits directly downstream of the MixColumns stage (and after ShiftRows in round 10): it XORs each incoming 128-bit state with the current round key and emits the result.
- One round key is expanded per accepted state, so the block steps through rounds 0..10 in order. After round 10 it wraps back to round 0 without reloading the cipher key.

## Interface
Parameters:
- none (AES-128 only; Nk=4, Nr=10 fixed)

Ports:
- clk  in  1  rising-edge clock; one clock, reset is synchronous and active-low
- rst_n  in  1  synchronous active-low reset
- key_load  in  1  one-cycle pulse: capture key_in as cipher key, restart at round 0
- key_in  in  128  cipher key; [127:120] = byte 0, column-major (w0 = [127:96])
- in_valid  in  1  din valid this cycle
- in_ready  out  1  registered; round key for out_round-next is available
- din  in  128  state from upstream, same byte order as key_in
- out_valid  out  1  one-cycle pulse, dout/out_round valid
- dout  out  128  din ^ round key
- out_round  out  4  round index (0..10) applied to dout

## Operation
- Storage:
  - ck_q: 128-bit copy of the cipher key.
  - rk_q: current round key.
  - rnd_q: 4-bit round index.
  - rcon_q: 8-bit round constant.
- FSM states:
  - IDLE: no key loaded; in_ready=0.
  - READY: rk_q valid for round rnd_q; in_ready=1.
  - EXPAND: one cycle computing the next key; in_ready=0.
- Transitions:
  - IDLE→READY on key_load. Sets rk_q=ck_q=key_in, rnd_q=0, rcon_q=8'h01.
  - READY→EXPAND on accept, where accept = in_valid & in_ready & ~key_load.
  - EXPAND→READY always.
- EXPAND, rnd_q<10: next key from rk_q.
  - temp = SubWord(RotWord(w3)) ^ {rcon_q,24'h0}.
  - w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - rnd_q+1.
  - rcon_q = xtime(rcon_q), i.e. (rcon<<1)^(msb?8'h1B:0). Sequence 01,02,04,08,10,20,40,80,1B,36.
- EXPAND, rnd_q==10 (wrap): rk_q=ck_q, rnd_q=0, rcon_q=8'h01. No S-box result is used.
- Accept in READY: dout<=din^rk_q, out_round<=rnd_q, out_valid<=1 for exactly one cycle.
- key_load in any state has priority:
  - Reloads the key, goes to READY at round 0, and aborts any expansion in progress.
  - A simultaneous in_valid is not accepted.
  - An out_valid already scheduled from the previous cycle's accept still fires.
- in_valid while in_ready=0: ignored. Upstream must hold din until accepted.
- No backpressure on the output; the consumer must take dout when out_valid=1.

## Timing
- Reset (rst_n=0 at a clock edge):
  - State IDLE.
  - in_ready=0, out_valid=0, dout=0, out_round=0.
  - rk_q, ck_q, rnd_q cleared; rcon_q=8'h01.
  - Reset mid-operation discards the key; key_load is required again.
- key_load at edge t: in_ready=1 from t+1.
- Accept at edge t: out_valid=1 and dout valid during cycle t+1; in_ready=0 during t+1, 1 again from t+2.
- Latency 1 cycle. Maximum throughput is one state per 2 cycles.
- Round-10 accept followed by wrap: in_ready=1 at t+2 with out_round-next=0.

## Structure
- Shared package aes_pkg:
  - RCON_INIT = 8'h01.
  - NR = 4'd10.
  - xtime function (the same GF(2^8) doubling used by MixColumns).
  - Byte/word slice constants.
- Sub-module aes_sbox: 8-bit combinational S-box, instantiated 4× for SubWord.
- FSM state encoding local to the block, 2 bits.

## Test plan
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c; din 3243f6a8885a308d313198a2e0370734.
  - Required: dout 193de3bea0f4e22b9ac68d2ae9f84808, out_round=0.
- Round 1:
  - Stimulus: din 046681e5e0cb199a48f8d37a2806264c.
  - Required: dout a49c7ff2689f352b6b5bea43026a5049, out_round=1. Internal key a0fafe1788542cb123a339392a6c7605.
- Rounds 2..10 with din=0:
  - Required: dout equals round keys; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next accept (din=0): out_round=0, dout=2b7e1516… (wrap).
- Handshake:
  - Stimulus: in_valid held high continuously.
  - Required: accepts every 2nd cycle. in_valid during EXPAND and before any key_load produces no out_valid.
- key_load collisions:
  - key_load with in_valid at the same edge: no accept, round restarts at 0.
  - key_load during EXPAND at round 5: next accept reports out_round=0 with the new key.
- Reset: rst_n=0 mid-sequence → all outputs 0, in_ready stays 0 until key_load.
